adder_share_arbiter: RTL and testbench

//  Shares one WIDTH-bit add datapath (sum = A + B + carry_in) among NUM_REQ requesters.

---
 rtl/adder_share_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//   Shares one WIDTH-bit adder (A + B + carry_in) among NUM_REQ requesters.
//   Round-robin grant, operands registered on accept, one compute cycle,
//   result registered and held until the consumer takes it. One transaction
//   in flight at a time, so sustained throughput is one result per 2 cycles.
//
// Optional feature: define ADDER_SHARE_OVF_EN to add the rsp_ovf port
// (signed two's-complement overflow of the registered sum).
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_ready  one-hot grant/accept (combinational, may follow rsp_ready)
//   req_a      operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      operand B, same packing
//   req_cin    per-requester carry in
//   rsp_valid  result valid
//   rsp_ready  result consumer ready
//   rsp_id     requester index owning the result
//   rsp_sum    low WIDTH bits of A + B + cin
//   rsp_cout   carry out (bit WIDTH of the sum)
//   rsp_ovf    signed overflow (only with ADDER_SHARE_OVF_EN)
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
`ifdef ADDER_SHARE_OVF_EN
  ,
  output logic                     rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               cin_q;
  logic [IDW-1:0]     id_q;
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [WIDTH-1:0]   rsp_sum_q;
  logic               rsp_cout_q;

  logic               grant_found_s;
  logic [IDW-1:0]     grant_idx_s;
  logic [IDW:0]       cand_s;
  logic               accept_en_s;
  logic               accept_s;
  logic [WIDTH:0]     sum_s;

`ifdef ADDER_SHARE_OVF_EN
  logic               rsp_ovf_q;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
`endif

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    cand_s        = {(IDW+1){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_s >= (IDW+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IDW+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[IDW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[IDW-1:0];
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
    if (grant_idx_s == IDW'(NUM_REQ-1)) begin
      rr_ptr_d = {IDW{1'b0}};
    end else begin
      rr_ptr_d = grant_idx_s + IDW'(1);
    end
  end

  // FSM output decode: when new operands may be accepted, and the grant.
  always_comb begin
    case (state_q)
      ST_IDLE: accept_en_s = 1'b1;
      ST_RESP: accept_en_s = rsp_ready;
      ST_CALC: accept_en_s = 1'b0;
      default: accept_en_s = 1'b0;
    endcase
    // Grant is forced low while reset is held so nothing is offered mid-reset.
    if (rst_n && accept_en_s && grant_found_s) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
    accept_s = |(req_valid & req_ready);
  end

  // FSM next-state logic.
  always_comb begin
    case (state_q)
      ST_IDLE: state_d = accept_s ? ST_CALC : ST_IDLE;
      ST_CALC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = accept_s ? ST_CALC : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign sum_s = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

  // Operand capture on accept and round-robin pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= {IDW{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      cin_q    <= 1'b0;
      id_q     <= {IDW{1'b0}};
    end else if (accept_s) begin
      rr_ptr_q <= rr_ptr_d;
      a_q      <= req_a[grant_idx_s*WIDTH +: WIDTH];
      b_q      <= req_b[grant_idx_s*WIDTH +: WIDTH];
      cin_q    <= req_cin[grant_idx_s];
      id_q     <= grant_idx_s;
    end
  end

  // Result registers: loaded only on the CALC->RESP edge, so they hold in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {IDW{1'b0}};
      rsp_sum_q   <= {WIDTH{1'b0}};
      rsp_cout_q  <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= (state_d == ST_RESP);
      if (state_q == ST_CALC) begin
        rsp_id_q   <= id_q;
        rsp_sum_q  <= sum_s[WIDTH-1:0];
        rsp_cout_q <= sum_s[WIDTH];
`ifdef ADDER_SHARE_OVF_EN
        rsp_ovf_q  <= ovf_f(a_q[WIDTH-1], b_q[WIDTH-1], sum_s[WIDTH-1]);
`endif
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
`ifdef ADDER_SHARE_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
//   Scoreboard bench: every accepted request pushes its expected result
//   (id, sum, carry, overflow) computed from the bench's operand tables;
//   every consumed response pops and compares. A small round-robin model
//   checks each grant. Directed phases cover reset, basic sums, carry and
//   overflow edges, all-valid round robin, response stall and mid-CALC reset.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

  localparam int NR = 4;
  localparam int W  = 64;
  localparam int IW = 2;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_a;
  logic [NR*W-1:0]   req_b;
  logic [NR-1:0]     req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;
`ifdef ADDER_SHARE_OVF_EN
  logic              rsp_ovf;
`endif

  adder_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .IDW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t        sb[$];
  int          gnt_log[$];
  int          gcyc_log[$];

  logic [W-1:0] a_tab   [NR][16];
  logic [W-1:0] b_tab   [NR][16];
  logic         cin_tab [NR][16];
  int           n_ops   [NR];
  int           pos     [NR];

  int           n_chk;
  int           n_err;
  int           cyc;
  int           tb_rr;
  logic [NR-1:0] last_acc;
  bit           drive_en;
  bit           prev_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_tab[r][n_ops[r]]   = a;
    b_tab[r][n_ops[r]]   = b;
    cin_tab[r][n_ops[r]] = c;
    n_ops[r]++;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < NR; i++) begin
      if (pos[i] != n_ops[i]) return 1'b0;
    end
    return (sb.size() == 0) && !rsp_valid;
  endfunction

  task automatic run_ops(input int max_cyc);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      @(posedge clk);
      #2;
      done = all_done();
      n++;
    end
    if (!done) chk("timeout", 128'd0, 128'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    gnt_log.delete();
    gcyc_log.delete();
    rst_n = 1'b1;
  endtask

  // Driver: each requester presents its next table entry until granted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drive_en) begin
        for (int i = 0; i < NR; i++) begin
          if (last_acc[i]) pos[i]++;
          req_valid[i] = (pos[i] < n_ops[i]);
          if (pos[i] < n_ops[i]) begin
            req_a[i*W +: W] = a_tab[i][pos[i]];
            req_b[i*W +: W] = b_tab[i][pos[i]];
            req_cin[i]      = cin_tab[i][pos[i]];
          end
        end
      end
    end
  end

  // Monitor: grant model, scoreboard push on accept, pop/compare on consume.
  initial begin
    logic [W:0]    full;
    logic [NR-1:0] acc;
    logic [NR-1:0] exp_oh;
    int            g;
    int            j;
    exp_t          e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        tb_rr      = 0;
        last_acc   = '0;
        prev_valid = 1'b0;
      end else begin
        acc = req_valid & req_ready;
        if (req_ready != '0) begin
          exp_oh = '0;
          for (int k = NR-1; k >= 0; k--) begin
            j = (tb_rr + k) % NR;
            if (req_valid[j]) exp_oh = NR'(1) << j;
          end
          chk("grant_rr", req_ready, exp_oh);
        end
        if (acc != '0) begin
          g = 0;
          for (int k = 0; k < NR; k++) if (acc[k]) g = k;
          full = {1'b0, a_tab[g][pos[g]]} + {1'b0, b_tab[g][pos[g]]} + (W+1)'(cin_tab[g][pos[g]]);
          e.id   = IW'(g);
          e.sum  = full[W-1:0];
          e.cout = full[W];
          e.ovf  = (a_tab[g][pos[g]][W-1] == b_tab[g][pos[g]][W-1]) && (full[W-1] != a_tab[g][pos[g]][W-1]);
          e.cyc  = cyc;
          sb.push_back(e);
          gnt_log.push_back(g);
          gcyc_log.push_back(cyc);
          tb_rr = (g == NR-1) ? 0 : g + 1;
        end
        if (rsp_valid && !prev_valid) begin
          if (sb.size() == 0) chk("spurious_rsp", 128'd1, 128'd0);
          else chk("latency", 128'(cyc - sb[0].cyc), 128'd2);
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 128'd1, 128'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_sum", rsp_sum, e.sum);
            chk("rsp_cout", rsp_cout, e.cout);
`ifdef ADDER_SHARE_OVF_EN
            chk("rsp_ovf", rsp_ovf, e.ovf);
`endif
          end
        end
        prev_valid = rsp_valid;
        last_acc   = acc;
      end
    end
  end

  initial begin
    int  n;
    n_chk = 0; n_err = 0; cyc = 0; tb_rr = 0;
    last_acc = '0; drive_en = 1'b0; prev_valid = 1'b0;
    for (int i = 0; i < NR; i++) begin n_ops[i] = 0; pos[i] = 0; end
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = {NR{1'b1}};
    req_a = {(NR*W){1'b1}};
    req_b = {(NR*W){1'b1}};
    req_cin = {NR{1'b1}};

    // Reset values, with requests pending during reset.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 128'd0);
    chk("rst_rsp_valid", rsp_valid, 128'd0);
    chk("rst_rsp_id", rsp_id, 128'd0);
    chk("rst_rsp_sum", rsp_sum, 128'd0);
    chk("rst_rsp_cout", rsp_cout, 128'd0);
`ifdef ADDER_SHARE_OVF_EN
    chk("rst_rsp_ovf", rsp_ovf, 128'd0);
`endif
    req_valid = '0;
    req_a = '0; req_b = '0; req_cin = '0;
    rst_n = 1'b1;
    drive_en = 1'b1;

    // Single requests, including carry and overflow boundaries.
    load(0, 64'd500, 64'd500, 1'b0);
    run_ops(40);
    load(1, 64'd667, 64'd9797979797, 1'b1);
    run_ops(40);
    load(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    load(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    load(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    run_ops(60);

    // All requesters valid together: round-robin 0,1,2,3,0 at one grant per 2 cycles.
    do_reset();
    load(0, 64'd2000, 64'd3000, 1'b0);
    load(0, 64'd11, 64'd22, 1'b1);
    load(1, 64'd10000, 64'd6545, 1'b0);
    load(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    load(2, 64'd2525, 64'd3560, 1'b0);
    load(3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    run_ops(80);
    if (gnt_log.size() >= 5) begin
      chk("rr_order0", 128'(gnt_log[0]), 128'd0);
      chk("rr_order1", 128'(gnt_log[1]), 128'd1);
      chk("rr_order2", 128'(gnt_log[2]), 128'd2);
      chk("rr_order3", 128'(gnt_log[3]), 128'd3);
      chk("rr_order4", 128'(gnt_log[4]), 128'd0);
      for (int k = 0; k < 4; k++) chk("b2b_gap", 128'(gcyc_log[k+1] - gcyc_log[k]), 128'd2);
    end else begin
      chk("rr_grant_count", 128'(gnt_log.size()), 128'd6);
    end

    // Consumer stall: outputs hold, no grants, regrant in the release cycle.
    do_reset();
    rsp_ready = 1'b0;
    load(1, 64'd123456789, 64'd987654321, 1'b1);
    load(2, 64'd42, 64'd58, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk("stall_rsp_seen", rsp_valid, 128'd1);
    for (int k = 0; k < 5; k++) begin
      if (sb.size() == 0) begin
        chk("stall_sb_nonempty", 128'd0, 128'd1);
      end else begin
        chk("stall_valid", rsp_valid, 128'd1);
        chk("stall_id", rsp_id, sb[0].id);
        chk("stall_sum", rsp_sum, sb[0].sum);
        chk("stall_cout", rsp_cout, sb[0].cout);
        chk("stall_no_grant", req_ready, 128'd0);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    #1 chk("regrant_same_cycle", req_ready, 128'b0100);
    run_ops(40);

    // Reset while in CALC: operation dropped, pointer back to requester 0.
    do_reset();
    load(2, 64'h1234, 64'h4321, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[2] && n < 20);
    chk("calc_grant_seen", req_ready[2], 128'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("calc_rst_valid", rsp_valid, 128'd0);
    chk("calc_rst_ready", req_ready, 128'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 128'd0);
    end
    gnt_log.delete();
    gcyc_log.delete();
    load(3, 64'd7, 64'd8, 1'b0);
    load(0, 64'd9, 64'd10, 1'b1);
    run_ops(40);
    if (gnt_log.size() > 0) chk("post_rst_first_grant", 128'(gnt_log[0]), 128'd0);
    else chk("post_rst_grant_count", 128'd0, 128'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
